// File: rtl/mac_lanes.sv
// mac_lanes: multi-lane signed multiply-accumulate engine.
//
// Each valid beat multiplies LANES image/kernel pairs, sums the products
// across lanes and accumulates that sum over a frame delimited by
// first/last. At frame end one arithmetically shifted, saturated result
// is emitted with a single-cycle valid strobe.
//
// Pipeline (a beat sampled on edge E reaches the outputs after edge E+4):
//   S1 input register -> S2 lane products -> S3 lane sum
//   -> S4 accumulator -> S5 shift/saturate output register
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   img        LANES packed signed samples, lane i at [i*IMG_WIDTH +: IMG_WIDTH]
//   ker        LANES packed signed weights, lane i at [i*KER_WIDTH +: KER_WIDTH]
//   val        beat valid; img/ker/first/last ignored when low
//   first      beat starts a new frame
//   last       beat ends the frame and triggers a result
//   result     saturated, shifted frame sum (holds between strobes)
//   result_val one-cycle strobe, result valid
//   result_sat high with result_val when saturation clipped the value
module mac_lanes #(
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 48,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES*IMG_WIDTH-1:0]   img,
    input  logic [LANES*KER_WIDTH-1:0]   ker,
    input  logic                         val,
    input  logic                         first,
    input  logic                         last,
    output logic [OUT_WIDTH-1:0]         result,
    output logic                         result_val,
    output logic                         result_sat
);

    localparam int PROD_WIDTH = IMG_WIDTH + KER_WIDTH;

    // Output range expressed at accumulator width for the saturation compare.
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX_C =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN_C =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Stage 1 state
    logic [LANES*IMG_WIDTH-1:0]     img_r;
    logic [LANES*KER_WIDTH-1:0]     ker_r;
    logic                           s1_val_r;
    logic                           s1_first_r;
    logic                           s1_last_r;

    // Stage 2 state
    logic signed [PROD_WIDTH-1:0]   mul_s  [LANES];
    logic signed [PROD_WIDTH-1:0]   prod_r [LANES];
    logic                           s2_val_r;
    logic                           s2_first_r;
    logic                           s2_last_r;

    // Stage 3 state
    logic signed [ACC_WIDTH-1:0]    sum_s;
    logic signed [ACC_WIDTH-1:0]    sum_r;
    logic                           s3_val_r;
    logic                           s3_first_r;
    logic                           s3_last_r;

    // Stage 4 state
    logic signed [ACC_WIDTH-1:0]    acc_next_s;
    logic signed [ACC_WIDTH-1:0]    acc_r;
    logic                           prev_last_r;
    logic                           s4_last_r;

    // Stage 5 combinational
    logic signed [ACC_WIDTH-1:0]    shifted_s;
    logic [OUT_WIDTH-1:0]           res_next_s;
    logic                           sat_next_s;

    // Stage 1: capture the beat; idle cycles present zero data and no flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_r      <= {(LANES*IMG_WIDTH){1'b0}};
            ker_r      <= {(LANES*KER_WIDTH){1'b0}};
            s1_val_r   <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
        end else if (val) begin
            img_r      <= img;
            ker_r      <= ker;
            s1_val_r   <= 1'b1;
            s1_first_r <= first;
            s1_last_r  <= last;
        end else begin
            img_r      <= {(LANES*IMG_WIDTH){1'b0}};
            ker_r      <= {(LANES*KER_WIDTH){1'b0}};
            s1_val_r   <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
        end
    end

    // Stage 2 combinational: exact signed product per lane.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mul_s[i] = PROD_WIDTH'($signed(img_r[i*IMG_WIDTH +: IMG_WIDTH]))
                     * PROD_WIDTH'($signed(ker_r[i*KER_WIDTH +: KER_WIDTH]));
        end
    end

    // Stage 2 register: lane products and beat flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                prod_r[i] <= {PROD_WIDTH{1'b0}};
            end
            s2_val_r   <= 1'b0;
            s2_first_r <= 1'b0;
            s2_last_r  <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                prod_r[i] <= mul_s[i];
            end
            s2_val_r   <= s1_val_r;
            s2_first_r <= s1_first_r;
            s2_last_r  <= s1_last_r;
        end
    end

    // Stage 3 combinational: sign-extended sum across all lanes.
    always_comb begin
        sum_s = {ACC_WIDTH{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + ACC_WIDTH'(prod_r[i]);
        end
    end

    // Stage 3 register: lane sum and beat flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r      <= {ACC_WIDTH{1'b0}};
            s3_val_r   <= 1'b0;
            s3_first_r <= 1'b0;
            s3_last_r  <= 1'b0;
        end else begin
            sum_r      <= sum_s;
            s3_val_r   <= s2_val_r;
            s3_first_r <= s2_first_r;
            s3_last_r  <= s2_last_r;
        end
    end

    // Stage 4 combinational: a valid beat after a last restarts the frame
    // even without first; bubbles leave the accumulator untouched.
    always_comb begin
        if (s3_val_r) begin
            if (s3_first_r || prev_last_r) begin
                acc_next_s = sum_r;
            end else begin
                acc_next_s = acc_r + sum_r;
            end
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Stage 4 register: accumulator, frame-boundary memory and result trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {ACC_WIDTH{1'b0}};
            prev_last_r <= 1'b0;
            s4_last_r   <= 1'b0;
        end else begin
            acc_r       <= acc_next_s;
            prev_last_r <= s3_val_r ? s3_last_r : prev_last_r;
            s4_last_r   <= s3_val_r & s3_last_r;
        end
    end

    // Stage 5 combinational: floor shift then clip to the output range.
    always_comb begin
        shifted_s = acc_r >>> SHIFT;
        if (shifted_s > OUT_MAX_C) begin
            res_next_s = OUT_MAX_C[OUT_WIDTH-1:0];
            sat_next_s = 1'b1;
        end else if (shifted_s < OUT_MIN_C) begin
            res_next_s = OUT_MIN_C[OUT_WIDTH-1:0];
            sat_next_s = 1'b1;
        end else begin
            res_next_s = shifted_s[OUT_WIDTH-1:0];
            sat_next_s = 1'b0;
        end
    end

    // Stage 5 register: result holds between strobes, sat only with the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            result     <= {OUT_WIDTH{1'b0}};
            result_val <= 1'b0;
            result_sat <= 1'b0;
        end else if (s4_last_r) begin
            result     <= res_next_s;
            result_val <= 1'b1;
            result_sat <= sat_next_s;
        end else begin
            result     <= result;
            result_val <= 1'b0;
            result_sat <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_lanes.sv
// Testbench for mac_lanes: two instances (SHIFT=0 and SHIFT=4) share the
// same stimulus; a reference model pushes expected results into a queue as
// beats are driven, and the monitor pops and compares on every strobe.
module tb_mac_lanes;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] img;
    logic [63:0] ker;
    logic        val;
    logic        first;
    logic        last;
    logic [31:0] res0, res4;
    logic        rv0, rs0, rv4, rs4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] r0;
        logic        s0;
        logic [31:0] r4;
        logic        s4;
        int          due;
    } exp_t;

    exp_t q[$];

    logic signed [47:0] m_acc;
    logic               m_prev_last;
    logic [31:0]        last0, last4;

    mac_lanes #(.IMG_WIDTH(16), .KER_WIDTH(16), .LANES(4), .ACC_WIDTH(48),
                .OUT_WIDTH(32), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .img(img), .ker(ker), .val(val),
        .first(first), .last(last),
        .result(res0), .result_val(rv0), .result_sat(rs0)
    );

    mac_lanes #(.IMG_WIDTH(16), .KER_WIDTH(16), .LANES(4), .ACC_WIDTH(48),
                .OUT_WIDTH(32), .SHIFT(4)) u_dut4 (
        .clk(clk), .rst(rst), .img(img), .ker(ker), .val(val),
        .first(first), .last(last),
        .result(res4), .result_val(rv4), .result_sat(rs4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    function automatic void sat_model(input logic signed [47:0] a, input int sh,
                                      output logic [31:0] r, output logic s);
        logic signed [47:0] t;
        longint v;
        t = a >>> sh;
        v = longint'(t);
        if (v > 64'sh7FFFFFFF) begin
            r = 32'h7FFFFFFF; s = 1'b1;
        end else if (v < -64'sh80000000) begin
            r = 32'h80000000; s = 1'b1;
        end else begin
            r = v[31:0]; s = 1'b0;
        end
    endfunction

    task automatic beat(input logic v, input logic f, input logic l,
                        input logic [63:0] iv, input logic [63:0] kv);
        longint sum;
        exp_t   e;
        @(negedge clk);
        val = v; first = f; last = l; img = iv; ker = kv;
        if (v) begin
            sum = 0;
            for (int i = 0; i < 4; i++) begin
                sum += longint'($signed(iv[i*16 +: 16])) * longint'($signed(kv[i*16 +: 16]));
            end
            if (f || m_prev_last) m_acc = 48'(sum);
            else                  m_acc = m_acc + 48'(sum);
            m_prev_last = l;
            if (l) begin
                e.due = cyc + 5;
                sat_model(m_acc, 0, e.r0, e.s0);
                sat_model(m_acc, 4, e.r4, e.s4);
                q.push_back(e);
            end
        end
    endtask

    // Idle cycles carry random data and flags that must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            val   = 1'b0;
            first = 1'($urandom);
            last  = 1'($urandom);
            img   = {$urandom, $urandom};
            ker   = {$urandom, $urandom};
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; val = 1'b0; first = 1'b0; last = 1'b0;
        q.delete();
        m_acc = 48'sd0; m_prev_last = 1'b0;
        last0 = 32'd0; last4 = 32'd0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rv0 || rv4) begin
            check_val("val_pair", {62'd0, rv0, rv4}, 64'd3);
            if (q.size() == 0) begin
                check_val("unexpected_strobe", 64'(q.size()), 64'd1);
            end else begin
                e = q.pop_front();
                check_val("latency", 64'(cyc), 64'(e.due));
                check_val("result_s0", {32'd0, res0}, {32'd0, e.r0});
                check_val("sat_s0", {63'd0, rs0}, {63'd0, e.s0});
                check_val("result_s4", {32'd0, res4}, {32'd0, e.r4});
                check_val("sat_s4", {63'd0, rs4}, {63'd0, e.s4});
                last0 = e.r0;
                last4 = e.r4;
            end
        end else begin
            check_val("idle_s0", {31'd0, res0, rs0}, {31'd0, last0, 1'b0});
            check_val("idle_s4", {31'd0, res4, rs4}, {31'd0, last4, 1'b0});
        end
    end

    initial begin
        int len;
        rst = 1'b1; val = 1'b0; first = 1'b0; last = 1'b0;
        img = 64'd0; ker = 64'd0;
        m_acc = 48'sd0; m_prev_last = 1'b0;
        last0 = 32'd0; last4 = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // last without any first after reset accumulates onto zero: 15
        beat(1'b1, 1'b0, 1'b1, pk(5, 0, 0, 0), pk(3, 0, 0, 0));
        // single-beat frame, back to back: 1*2+2*2+3*2+4*2 = 20
        beat(1'b1, 1'b1, 1'b1, pk(1, 2, 3, 4), pk(2, 2, 2, 2));
        idle(6);

        // three beats with two idle cycles between: -45
        beat(1'b1, 1'b1, 1'b0, pk(-3, 0, 0, 0), pk(5, 0, 0, 0));
        idle(2);
        beat(1'b1, 1'b0, 1'b0, pk(-3, 0, 0, 0), pk(5, 0, 0, 0));
        idle(2);
        beat(1'b1, 1'b0, 1'b1, pk(-3, 0, 0, 0), pk(5, 0, 0, 0));
        idle(6);

        // positive then negative saturation
        beat(1'b1, 1'b1, 1'b0, pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767));
        beat(1'b1, 1'b0, 1'b1, pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767));
        beat(1'b1, 1'b1, 1'b0, pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767));
        beat(1'b1, 1'b0, 1'b1, pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767));
        idle(6);

        // frame A (10) then implicit restart without first (7)
        beat(1'b1, 1'b1, 1'b0, pk(2, 0, 0, 0), pk(3, 0, 0, 0));
        beat(1'b1, 1'b0, 1'b1, pk(4, 0, 0, 0), pk(1, 0, 0, 0));
        beat(1'b1, 1'b0, 1'b1, pk(7, 0, 0, 0), pk(1, 0, 0, 0));
        idle(6);

        // shift boundaries: 0x100 -> 0x10, -17 -> -2
        beat(1'b1, 1'b1, 1'b1, pk(256, 0, 0, 0), pk(1, 0, 0, 0));
        beat(1'b1, 1'b1, 1'b1, pk(-17, 0, 0, 0), pk(1, 0, 0, 0));
        idle(6);

        // flags on an idle beat must not split the frame: 8
        beat(1'b1, 1'b1, 1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1));
        beat(1'b0, 1'b1, 1'b1, pk(100, 100, 100, 100), pk(9, 9, 9, 9));
        beat(1'b1, 1'b0, 1'b1, pk(1, 1, 1, 1), pk(1, 1, 1, 1));
        idle(6);

        // reset while a frame is in flight, then a fresh single-beat frame: 1
        beat(1'b1, 1'b1, 1'b0, pk(9, 9, 9, 9), pk(9, 9, 9, 9));
        beat(1'b1, 1'b0, 1'b0, pk(9, 9, 9, 9), pk(9, 9, 9, 9));
        beat(1'b1, 1'b0, 1'b1, pk(9, 9, 9, 9), pk(9, 9, 9, 9));
        do_reset(1);
        beat(1'b1, 1'b1, 1'b1, pk(1, 0, 0, 0), pk(1, 0, 0, 0));
        idle(6);

        // random frames with bubbles and occasional missing first
        for (int fr = 0; fr < 30; fr++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                beat(1'b1, (b == 0) ? 1'($urandom) : 1'b0, (b == len - 1),
                     {$urandom, $urandom}, {$urandom, $urandom});
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end

        idle(8);
        check_val("drain", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
